// File: rtl/scan_decoder_low.sv
// Registered N-to-2^N active-low decoder with manual select or prescaled auto-scan.
// Drives digit/row strobes; wrap pulses once per completed scan of LAST outputs.
module scan_decoder_low #(
  parameter int N    = 4,
  parameter int DIV  = 4,
  parameter int LAST = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              e,
  input  logic              mode,
  input  logic [N-1:0]      w,
  output logic [2**N-1:0]   y,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int OUTS = 2**N;
  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [N:0]    LAST_W   = (N+1)'(LAST);
  localparam logic [N-1:0]  IDX_LAST = N'(LAST - 1);

  logic [PW-1:0]   pre_q;
  logic [PW-1:0]   pre_d;
  logic [N-1:0]    idx_d;
  logic            wrap_d;
  logic [OUTS-1:0] y_d;

  // Next index/prescaler; an index left at or beyond LAST by manual mode restarts at 0 silently.
  always_comb begin
    idx_d  = idx;
    pre_d  = pre_q;
    wrap_d = 1'b0;
    if (e) begin
      if (!mode) begin
        idx_d = w;
        pre_d = '0;
      end else if (pre_q == PRE_LAST) begin
        pre_d = '0;
        if (idx == IDX_LAST) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else if ({1'b0, idx} >= LAST_W) begin
          idx_d = '0;
        end else begin
          idx_d = idx + 1'b1;
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  // y decodes the index being written on this same edge, so y and idx never disagree.
  always_comb begin
    y_d = '1;
    for (int i = 0; i < OUTS; i++) begin
      y_d[i] = ~(e && ({1'b0, idx_d} < LAST_W) && (idx_d == N'(i)));
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      y     <= '1;
      idx   <= '0;
      wrap  <= 1'b0;
      pre_q <= '0;
    end else begin
      y     <= y_d;
      idx   <= idx_d;
      wrap  <= wrap_d;
      pre_q <= pre_d;
    end
  end

endmodule

// File: tb/tb_scan_decoder_low.sv
// Directed bench for scan_decoder_low: default instance (DIV=4, LAST=16)
// plus a truncated instance (DIV=1, LAST=10).
module tb_scan_decoder_low;

  logic        clock = 1'b0;
  logic        resetn;
  logic        e, mode;
  logic [3:0]  w;
  logic [15:0] y;
  logic [3:0]  idx;
  logic        wrap;
  logic        e_t, mode_t;
  logic [3:0]  w_t;
  logic [15:0] y_t;
  logic [3:0]  idx_t;
  logic        wrap_t;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        e;
    logic        mode;
    logic [3:0]  w;
    logic [15:0] exp_y;
    logic [3:0]  exp_idx;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs[$];

  scan_decoder_low #(.N(4), .DIV(4), .LAST(16)) dut (
    .clock(clock), .resetn(resetn), .e(e), .mode(mode), .w(w),
    .y(y), .idx(idx), .wrap(wrap)
  );

  scan_decoder_low #(.N(4), .DIV(1), .LAST(10)) dut_t (
    .clock(clock), .resetn(resetn), .e(e_t), .mode(mode_t), .w(w_t),
    .y(y_t), .idx(idx_t), .wrap(wrap_t)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    e    = v.e;
    mode = v.mode;
    w    = v.w;
    tick();
    check_output("vec_y", 32'(y), 32'(v.exp_y));
    check_output("vec_idx", 32'(idx), 32'(v.exp_idx));
    check_output("vec_wrap", 32'(wrap), 32'(v.exp_wrap));
  endtask

  initial begin
    int wrap_count;
    int first_wrap;
    logic [3:0]  exp_idx;
    logic [15:0] exp_y;
    logic        exp_wrap;

    for (int i = 0; i < 16; i++) begin
      vec_t v;
      v.e = 1'b1; v.mode = 1'b0; v.w = i[3:0];
      v.exp_y = ~(16'h1 << i); v.exp_idx = i[3:0]; v.exp_wrap = 1'b0;
      vecs.push_back(v);
    end
    vecs.push_back('{1'b1, 1'b0, 4'd5, 16'hFFDF, 4'd5, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd9, 16'hFFFF, 4'd5, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'd9, 16'hFFFF, 4'd5, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'd9, 16'hFDFF, 4'd9, 1'b0});

    resetn = 1'b0;
    e = 1'b0; mode = 1'b0; w = 4'd0;
    e_t = 1'b0; mode_t = 1'b0; w_t = 4'd0;
    #12;
    check_output("reset_y", 32'(y), 32'hFFFF);
    check_output("reset_idx", 32'(idx), 32'd0);
    check_output("reset_wrap", 32'(wrap), 32'd0);
    resetn = 1'b1;
    tick();

    foreach (vecs[k]) apply_stimulus(vecs[k]);

    // Scan timing from idx=0: step every 4 clocks, wrap every 64.
    w = 4'd0; tick();
    mode = 1'b1;
    wrap_count = 0;
    first_wrap = 0;
    for (int c = 1; c <= 130; c++) begin
      tick();
      exp_idx  = 4'((c / 4) % 16);
      exp_wrap = (c % 4 == 0) && ((c / 4) % 16 == 0);
      exp_y    = ~(16'h1 << exp_idx);
      check_output("scan_idx", 32'(idx), 32'(exp_idx));
      check_output("scan_wrap", 32'(wrap), 32'(exp_wrap));
      check_output("scan_y", 32'(y), 32'(exp_y));
      if (wrap) begin
        wrap_count++;
        if (first_wrap == 0) first_wrap = c;
      end
    end
    check_output("scan_wrap_count", 32'(wrap_count), 32'd2);
    check_output("scan_first_wrap", 32'(first_wrap), 32'd64);

    // Freeze at idx=3 with prescaler=2.
    mode = 1'b0; w = 4'd3; tick();
    mode = 1'b1; tick(); tick();
    check_output("freeze_pre_idx", 32'(idx), 32'd3);
    e = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_output("freeze_y", 32'(y), 32'hFFFF);
      check_output("freeze_idx", 32'(idx), 32'd3);
      check_output("freeze_wrap", 32'(wrap), 32'd0);
    end
    e = 1'b1; tick();
    check_output("thaw_y", 32'(y), 32'hFFF7);
    check_output("thaw_idx", 32'(idx), 32'd3);
    tick();
    check_output("thaw_step_idx", 32'(idx), 32'd4);
    check_output("thaw_step_y", 32'(y), 32'hFFEF);

    // Scan -> manual -> (frozen mode change) -> scan.
    mode = 1'b0; w = 4'd6; tick();
    mode = 1'b1; tick();
    check_output("sw_scan_idx", 32'(idx), 32'd6);
    check_output("sw_scan_y", 32'(y), 32'hFFBF);
    mode = 1'b0; w = 4'd2; tick();
    check_output("sw_man_idx", 32'(idx), 32'd2);
    check_output("sw_man_y", 32'(y), 32'hFFFB);
    e = 1'b0; mode = 1'b1;
    tick(); tick();
    check_output("sw_frozen_y", 32'(y), 32'hFFFF);
    check_output("sw_frozen_idx", 32'(idx), 32'd2);
    e = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_output("sw_hold_idx", 32'(idx), 32'd2);
      check_output("sw_hold_y", 32'(y), 32'hFFFB);
    end
    tick();
    check_output("sw_step_idx", 32'(idx), 32'd3);
    check_output("sw_step_y", 32'(y), 32'hFFF7);

    // Asynchronous reset between edges mid-scan at idx=7.
    mode = 1'b0; w = 4'd7; tick();
    mode = 1'b1; tick();
    check_output("prerst_y", 32'(y), 32'hFF7F);
    #3 resetn = 1'b0;
    #1;
    check_output("async_rst_y", 32'(y), 32'hFFFF);
    check_output("async_rst_idx", 32'(idx), 32'd0);
    check_output("async_rst_wrap", 32'(wrap), 32'd0);
    tick();
    check_output("held_rst_idx", 32'(idx), 32'd0);
    resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_output("postrst_hold_idx", 32'(idx), 32'd0);
    end
    tick();
    check_output("postrst_step_idx", 32'(idx), 32'd1);
    e = 1'b0;

    // Truncated scan, DIV=1, LAST=10.
    e_t = 1'b1; mode_t = 1'b0; w_t = 4'd0; tick();
    check_output("t_man_y", 32'(y_t), 32'hFFFE);
    mode_t = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      tick();
      exp_idx  = 4'(c % 10);
      exp_wrap = (c % 10 == 0);
      exp_y    = ~(16'h1 << exp_idx);
      check_output("t_scan_idx", 32'(idx_t), 32'(exp_idx));
      check_output("t_scan_wrap", 32'(wrap_t), 32'(exp_wrap));
      check_output("t_scan_y", 32'(y_t), 32'(exp_y));
      check_output("t_scan_upper", 32'(y_t[15:10]), 32'h3F);
    end
    mode_t = 1'b0; w_t = 4'd12; tick();
    check_output("t_invalid_y", 32'(y_t), 32'hFFFF);
    check_output("t_invalid_idx", 32'(idx_t), 32'd12);
    mode_t = 1'b1; tick();
    check_output("t_recover_idx", 32'(idx_t), 32'd0);
    check_output("t_recover_wrap", 32'(wrap_t), 32'd0);
    check_output("t_recover_y", 32'(y_t), 32'hFFFE);
    mode_t = 1'b0; w_t = 4'd9; tick();
    check_output("t_last_y", 32'(y_t), 32'hFDFF);
    mode_t = 1'b1; tick();
    check_output("t_last_wrap", 32'(wrap_t), 32'd1);
    check_output("t_last_idx", 32'(idx_t), 32'd0);
    tick();
    check_output("t_wrap_pulse", 32'(wrap_t), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
